// File: rtl/eq_cmp_pkg.sv
// Shared types and helpers for the eq_cmp_pipe equality checker.
package eq_cmp_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    EQ  = 2'd0,
    NE  = 2'd1,
    MEQ = 2'd2,
    MNE = 2'd3
  } eq_cmp_mode_e;

  function automatic int lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/eq_cmp_lane.sv
// Combinational LANE_W-bit masked equality compare; masked-off bits always match.
module eq_cmp_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [LANE_W-1:0] m,
  output logic              eq
);

  always_comb eq = &(~(a ^ b) | ~m);

endmodule

// File: rtl/eq_cmp_pipe.sv
// Two-stage back-pressured equality checker with saturating statistics and sticky error.
// Optional first-error operand capture enabled by defining EQ_CMP_ERR_CAPTURE_EN.
module eq_cmp_pipe
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_mask,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              in_expect,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_result,
  output logic              out_err,
  output logic [CNT_W-1:0]  cmp_count,
  output logic [CNT_W-1:0]  match_count,
  output logic              sticky_err,
  input  logic              clear,
  output logic [WIDTH-1:0]  err_a,
  output logic [WIDTH-1:0]  err_b
);

  localparam int LANES = lanes(WIDTH, LANE_W);

  if (WIDTH % LANE_W != 0) begin : g_width_chk
    $error("eq_cmp_pipe: WIDTH must be a multiple of LANE_W");
  end

  logic s2_load, s1_adv, in_fire, out_fire;

  eq_cmp_mode_e      in_mode_e;
  logic [WIDTH-1:0]  lane_mask;
  logic [LANES-1:0]  lane_eq;

  logic              s1_valid_q, s1_valid_d;
  logic [LANES-1:0]  s1_lane_eq_q, s1_lane_eq_d;
  eq_cmp_mode_e      s1_mode_q, s1_mode_d;
  logic              s1_expect_q, s1_expect_d;
  logic              s1_eq, s1_result;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_result_q, s2_result_d;
  logic              s2_err_q, s2_err_d;

  logic [CNT_W-1:0]  cmp_count_q, cmp_count_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic              sticky_q, sticky_d;

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = !s1_valid_q || s2_load;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  always_comb begin
    in_mode_e = eq_cmp_mode_e'(in_mode);
    lane_mask = (in_mode_e == MEQ || in_mode_e == MNE) ? in_mask : '1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    eq_cmp_lane #(.LANE_W(LANE_W)) u_lane (
      .a  (in_a[g*LANE_W +: LANE_W]),
      .b  (in_b[g*LANE_W +: LANE_W]),
      .m  (lane_mask[g*LANE_W +: LANE_W]),
      .eq (lane_eq[g])
    );
  end

  always_comb begin
    s1_eq     = &s1_lane_eq_q;
    s1_result = (s1_mode_q == NE || s1_mode_q == MNE) ? ~s1_eq : s1_eq;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_lane_eq_d = s1_lane_eq_q;
    s1_mode_d    = s1_mode_q;
    s1_expect_d  = s1_expect_q;
    if (in_fire) begin
      s1_valid_d   = 1'b1;
      s1_lane_eq_d = lane_eq;
      s1_mode_d    = in_mode_e;
      s1_expect_d  = in_expect;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_err_d    = s2_err_q;
    if (s2_load) s2_valid_d = s1_valid_q;
    // Payload only moves on a real advance so the presented result stays stable while stalled.
    if (s1_adv) begin
      s2_result_d = s1_result;
      s2_err_d    = s1_result ^ s1_expect_q;
    end
  end

  always_comb begin
    cmp_count_d   = cmp_count_q;
    match_count_d = match_count_q;
    sticky_d      = sticky_q;
    if (clear) begin
      cmp_count_d   = '0;
      match_count_d = '0;
      sticky_d      = 1'b0;
    end else if (out_fire) begin
      if (cmp_count_q != '1) cmp_count_d = cmp_count_q + CNT_W'(1);
      if (s2_result_q && (match_count_q != '1)) match_count_d = match_count_q + CNT_W'(1);
      sticky_d = sticky_q | s2_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lane_eq_q  <= '0;
      s1_mode_q     <= EQ;
      s1_expect_q   <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= 1'b0;
      s2_err_q      <= 1'b0;
      cmp_count_q   <= '0;
      match_count_q <= '0;
      sticky_q      <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lane_eq_q  <= s1_lane_eq_d;
      s1_mode_q     <= s1_mode_d;
      s1_expect_q   <= s1_expect_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_err_q      <= s2_err_d;
      cmp_count_q   <= cmp_count_d;
      match_count_q <= match_count_d;
      sticky_q      <= sticky_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_err     = s2_err_q;
  assign cmp_count   = cmp_count_q;
  assign match_count = match_count_q;
  assign sticky_err  = sticky_q;

`ifdef EQ_CMP_ERR_CAPTURE_EN
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d;
  logic             err_held_q, err_held_d;

  always_comb begin
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    err_a_d    = err_a_q;
    err_b_d    = err_b_q;
    err_held_d = err_held_q;
    if (in_fire) begin
      s1_a_d = in_a;
      s1_b_d = in_b;
    end
    if (s1_adv) begin
      s2_a_d = s1_a_q;
      s2_b_d = s1_b_q;
    end
    // Clear only re-arms capture; the last captured operands remain visible.
    if (clear) begin
      err_held_d = 1'b0;
    end else if (out_fire && s2_err_q && !err_held_q) begin
      err_held_d = 1'b1;
      err_a_d    = s2_a_q;
      err_b_d    = s2_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      err_a_q    <= '0;
      err_b_q    <= '0;
      err_held_q <= 1'b0;
    end else begin
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      err_held_q <= err_held_d;
    end
  end

  assign err_a = err_a_q;
  assign err_b = err_b_q;
`else
  assign err_a = '0;
  assign err_b = '0;
`endif

endmodule

// File: tb/tb_eq_cmp_pipe.sv
// Scoreboard bench for eq_cmp_pipe (CNT_W=3 so saturation is reachable).
module tb_eq_cmp_pipe;
  import eq_cmp_pkg::*;

  localparam int W    = 32;
  localparam int CW   = 3;
  localparam int MAXC = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_expect;
  logic [W-1:0]  in_a, in_b, in_mask;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready, out_result, out_err;
  logic [CW-1:0] cmp_count, match_count;
  logic          sticky_err, clear;
  logic [W-1:0]  err_a, err_b;

  eq_cmp_pipe #(.WIDTH(W), .LANE_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_mode(in_mode),
    .in_expect(in_expect), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .cmp_count(cmp_count),
    .match_count(match_count), .sticky_err(sticky_err), .clear(clear),
    .err_a(err_a), .err_b(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          res;
    bit          err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int          issue;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   nx_res, nx_err, nx_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input side: record the hand-computed expectation for each accepted transaction.
  initial forever begin
    @(negedge clk);
    if (rst_n && in_valid && in_ready)
      sbq.push_back('{nx_res, nx_err, in_a, in_b, cyc, nx_lat});
  end

  // Output side: pop on every output transfer, track statistics model.
  initial begin
    exp_t e;
    int   m_cmp, m_match;
    bit   m_sticky, m_cap, prev_stall, prev_res, prev_err;
    logic [W-1:0] m_ea, m_eb;
    m_cmp = 0; m_match = 0; m_sticky = 0; m_cap = 0; m_ea = '0; m_eb = '0;
    prev_stall = 0; prev_res = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        m_cmp = 0; m_match = 0; m_sticky = 0; m_cap = 0; m_ea = '0; m_eb = '0;
        prev_stall = 0;
      end else begin
        chk("cmp_count", 64'(cmp_count), 64'(m_cmp));
        chk("match_count", 64'(match_count), 64'(m_match));
        chk("sticky_err", 64'(sticky_err), 64'(m_sticky));
`ifdef EQ_CMP_ERR_CAPTURE_EN
        chk("err_a", 64'(err_a), 64'(m_ea));
        chk("err_b", 64'(err_b), 64'(m_eb));
`else
        chk("err_a_tied", 64'(err_a), 64'(0));
        chk("err_b_tied", 64'(err_b), 64'(0));
`endif
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_result", 64'(out_result), 64'(prev_res));
          chk("hold_err", 64'(out_err), 64'(prev_err));
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got result %0b with empty scoreboard, expected none", out_result);
          end else begin
            e = sbq.pop_front();
            chk("result", 64'(out_result), 64'(e.res));
            chk("out_err", 64'(out_err), 64'(e.err));
            if (e.chk_lat) chk("latency", 64'(cyc - e.issue), 64'(2));
            if (clear) begin
              m_cmp = 0; m_match = 0; m_sticky = 0; m_cap = 0;
            end else begin
              if (m_cmp < MAXC) m_cmp++;
              if (e.res && m_match < MAXC) m_match++;
              m_sticky = m_sticky | e.err;
              if (e.err && !m_cap) begin
                m_cap = 1; m_ea = e.a; m_eb = e.b;
              end
            end
          end
        end else if (clear) begin
          m_cmp = 0; m_match = 0; m_sticky = 0; m_cap = 0;
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_err   = out_err;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                      input eq_cmp_mode_e mode, input bit ex, input bit r, input bit er, input bit lat);
    bit ok;
    in_a = a; in_b = b; in_mask = m; in_mode = mode; in_expect = ex;
    nx_res = r; nx_err = er; nx_lat = lat;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_mask = '0; in_mode = 2'd0;
    in_expect = 0; out_ready = 1; clear = 0; nx_res = 0; nx_err = 0; nx_lat = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_cmp", 64'(cmp_count), 64'(0));
    chk("rst_match", 64'(match_count), 64'(0));
    chk("rst_sticky", 64'(sticky_err), 64'(0));
    chk("rst_err_a", 64'(err_a), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // EQ stream, full throughput
    send(32'd0,    32'd0,    '0, EQ, 1, 1, 0, 1);
    send(32'd1,    32'd0,    '0, EQ, 0, 0, 0, 1);
    send(32'd1,    32'd1,    '0, EQ, 1, 1, 0, 1);
    send(32'd1002, 32'd1001, '0, EQ, 0, 0, 0, 1);
    send(32'd1001, 32'd1001, '0, EQ, 1, 1, 0, 1);
    idle(4);
    chk("eq_cmp5", 64'(cmp_count), 64'(5));
    chk("eq_match3", 64'(match_count), 64'(3));
    chk("eq_sticky0", 64'(sticky_err), 64'(0));

    // Masked NE ignores the differing top byte; plain NE sees it
    send(32'hFF00_0000, 32'h0, 32'h00FF_FFFF, MNE, 0, 0, 0, 1);
    send(32'hFF00_0000, 32'h0, 32'h00FF_FFFF, NE,  0, 1, 1, 1);
    idle(4);
    chk("ne_sticky1", 64'(sticky_err), 64'(1));
    chk("ne_cmp7", 64'(cmp_count), 64'(7));
    chk("ne_match4", 64'(match_count), 64'(4));
    pulse_clear();
    chk("clr_cmp0", 64'(cmp_count), 64'(0));
    chk("clr_sticky0", 64'(sticky_err), 64'(0));

    // Back-pressure: 4 offers over a stall, only 2 fit
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'(i + 10); in_b = (i == 1) ? 32'd99 : 32'(i + 10);
      in_mask = '0; in_mode = EQ; in_expect = 1;
      nx_res = (i != 1); nx_err = (i == 1); nx_lat = 0;
      in_valid = 1;
      @(negedge clk);
      if (i >= 2) chk("bp_in_ready0", 64'(in_ready), 64'(0));
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    idle(1);
    chk("bp_accepted2", 64'(acc), 64'(2));
    out_ready = 1;
    #1 chk("bp_ready_comb", 64'(in_ready), 64'(1));
    idle(4);

    // Saturation at all-ones for CNT_W=3
    pulse_clear();
    for (int i = 0; i < 10; i++) send(32'(i), 32'(i), '0, EQ, 1, 1, 0, 1);
    idle(4);
    chk("sat_cmp7", 64'(cmp_count), 64'(7));
    chk("sat_match7", 64'(match_count), 64'(7));

    // Clear coincident with an erroring output transfer
    in_a = 32'd1; in_b = 32'd2; in_mask = '0; in_mode = EQ; in_expect = 1;
    nx_res = 0; nx_err = 1; nx_lat = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 chk("clrx_out_valid", 64'(out_valid), 64'(1));
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
    chk("clrx_cmp0", 64'(cmp_count), 64'(0));
    chk("clrx_match0", 64'(match_count), 64'(0));
    chk("clrx_sticky0", 64'(sticky_err), 64'(0));

    // First-error capture
    send(32'd5, 32'd6, '0, EQ, 1, 0, 1, 1);
    send(32'd7, 32'd9, '0, EQ, 1, 0, 1, 1);
    idle(4);
`ifdef EQ_CMP_ERR_CAPTURE_EN
    chk("cap_a5", 64'(err_a), 64'(5));
    chk("cap_b6", 64'(err_b), 64'(6));
`else
    chk("cap_a0", 64'(err_a), 64'(0));
`endif
    pulse_clear();
    send(32'd3, 32'd4, '0, EQ, 1, 0, 1, 1);
    idle(4);
`ifdef EQ_CMP_ERR_CAPTURE_EN
    chk("cap_a3", 64'(err_a), 64'(3));
    chk("cap_b4", 64'(err_b), 64'(4));
`else
    chk("cap_b0", 64'(err_b), 64'(0));
`endif

    // Vacuous masked compare
    send(32'h1234, 32'hFFFF, 32'h0, MEQ, 1, 1, 0, 1);
    send(32'h1234, 32'hFFFF, 32'h0, MNE, 1, 0, 1, 1);
    idle(4);

    // Reset with two transactions in flight
    in_a = 32'd20; in_b = 32'd20; in_mode = EQ; in_expect = 1;
    nx_res = 1; nx_err = 0; nx_lat = 1; in_valid = 1;
    @(posedge clk);
    #1 in_a = 32'd21; in_b = 32'd21;
    @(posedge clk);
    #1 in_valid = 0;
    chk("inflight_valid", 64'(out_valid), 64'(1));
    #1 rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_cmp", 64'(cmp_count), 64'(0));
    chk("arst_match", 64'(match_count), 64'(0));
    chk("arst_sticky", 64'(sticky_err), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    send(32'd8, 32'd8, '0, EQ, 1, 1, 0, 1);
    idle(4);
    chk("post_rst_cmp1", 64'(cmp_count), 64'(1));
    chk("sb_empty", 64'(sbq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
